// File: rtl/dm_pkg.sv
// rtl/dm_pkg.sv - shared types and reset defaults for the dm hop sequencer
package dm_pkg;

  typedef enum logic [1:0] {
    HOLD     = 2'd0,
    SEQ      = 2'd1,
    PINGPONG = 2'd2,
    EXT      = 2'd3
  } dm_mode_e;

  // Fixed-width carrier for the defaults; modules resize to their own WIDTH.
  typedef struct packed {
    logic [15:0] c;
    logic [15:0] b;
    logic [15:0] n;
    logic [15:0] p;
  } dm_dflt_t;

  localparam dm_dflt_t DM_LOW  = '{c: 16'd49, b: 16'd29, n: 16'd21, p: 16'd20};
  localparam dm_dflt_t DM_HIGH = '{c: 16'd51, b: 16'd20, n: 16'd20, p: 16'd19};

endpackage

// File: rtl/dm_hop_table.sv
// rtl/dm_hop_table.sv - parameter-set register file with write-through read port
module dm_hop_table
  import dm_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic                 clk_mod,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_addr,
  input  logic [4*WIDTH-1:0]   wr_data,
  input  logic [IDX_W-1:0]     rd_addr,
  input  logic                 byp_en,
  output logic [4*WIDTH-1:0]   rd_data
);

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] p;
  } dm_param_t;

  dm_param_t tbl [DEPTH];
  logic      wr_ok;

  function automatic dm_param_t dflt(input int i);
    dm_dflt_t  d;
    dm_param_t r;
    d   = (i == 1) ? DM_HIGH : DM_LOW;
    r.c = WIDTH'(d.c);
    r.b = WIDTH'(d.b);
    r.n = WIDTH'(d.n);
    r.p = WIDTH'(d.p);
    return r;
  endfunction

  assign wr_ok = wr_en && (int'(wr_addr) < DEPTH);

  always_ff @(posedge clk_mod or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl[i] <= dflt(i);
      end
    end else if (wr_ok) begin
      tbl[wr_addr] <= wr_data;
    end
  end

  // Bypass only on hop loads; HOLD reloads see writes one cycle late.
  always_comb begin
    rd_data = tbl[rd_addr];
    if (byp_en && wr_ok && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end

endmodule

// File: rtl/dm_hop_seq.sv
// rtl/dm_hop_seq.sv - frequency-hopping sequencer driving the dm core parameters
module dm_hop_seq
  import dm_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 4,
  parameter int DWELL_W = 8,
  parameter int IDX_W   = $clog2(DEPTH)
) (
  input  logic               clk_mod,
  input  logic               rst,
  input  logic               en,
  input  logic [1:0]         mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [IDX_W-1:0]   ext_sel,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [WIDTH-1:0]   wr_c,
  input  logic [WIDTH-1:0]   wr_b,
  input  logic [WIDTH-1:0]   wr_n,
  input  logic [WIDTH-1:0]   wr_p,
  output logic [WIDTH-1:0]   dm_c,
  output logic [WIDTH-1:0]   dm_b,
  output logic [WIDTH-1:0]   dm_n,
  output logic [WIDTH-1:0]   dm_p,
  output logic [IDX_W-1:0]   idx,
  output logic               hop
);

  typedef struct packed {
    logic [WIDTH-1:0] c;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] p;
  } dm_param_t;

  localparam logic [IDX_W-1:0]   LAST  = IDX_W'(DEPTH - 1);
  localparam logic [IDX_W-1:0]   ONE   = IDX_W'(1);
  localparam logic [DWELL_W-1:0] CNT_1 = DWELL_W'(1);

  dm_mode_e           mode_e;
  logic [DWELL_W-1:0] cnt;
  logic               dir_up;
  logic [IDX_W-1:0]   idx_q;
  dm_param_t          dm_q;
  logic               hop_q;

  logic               hop_go;
  logic               load;
  logic [IDX_W-1:0]   nxt_idx;
  logic               nxt_dir;
  logic [IDX_W-1:0]   rd_addr;
  logic [4*WIDTH-1:0] rd_data;

  assign mode_e  = dm_mode_e'(mode);
  assign hop_go  = en && (mode_e != HOLD) && (cnt >= dwell);
  assign load    = hop_go || (en && (mode_e == HOLD));
  assign rd_addr = hop_go ? nxt_idx : idx_q;

  always_comb begin
    nxt_idx = idx_q;
    nxt_dir = dir_up;
    case (mode_e)
      SEQ: begin
        nxt_idx = (idx_q == LAST) ? '0 : idx_q + ONE;
      end
      PINGPONG: begin
        if (dir_up) begin
          if (idx_q == LAST) begin
            nxt_idx = idx_q - ONE;
            nxt_dir = 1'b0;
          end else begin
            nxt_idx = idx_q + ONE;
          end
        end else begin
          if (idx_q == '0) begin
            nxt_idx = ONE;
            nxt_dir = 1'b1;
          end else begin
            nxt_idx = idx_q - ONE;
          end
        end
      end
      EXT: begin
        nxt_idx = (ext_sel > LAST) ? LAST : ext_sel;
      end
      default: begin
        nxt_idx = idx_q;
      end
    endcase
  end

  always_ff @(posedge clk_mod or negedge rst) begin
    if (!rst) begin
      cnt    <= '0;
      idx_q  <= '0;
      dir_up <= 1'b1;
      hop_q  <= 1'b0;
      dm_q   <= '{c: WIDTH'(DM_LOW.c), b: WIDTH'(DM_LOW.b),
                  n: WIDTH'(DM_LOW.n), p: WIDTH'(DM_LOW.p)};
    end else begin
      hop_q <= hop_go;
      if (hop_go) begin
        cnt    <= '0;
        idx_q  <= nxt_idx;
        dir_up <= nxt_dir;
      end else if (en && (mode_e != HOLD)) begin
        cnt <= cnt + CNT_1;
      end
      if (load) begin
        dm_q <= rd_data;
      end
    end
  end

  dm_hop_table #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_table (
    .clk_mod (clk_mod),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data ({wr_c, wr_b, wr_n, wr_p}),
    .rd_addr (rd_addr),
    .byp_en  (hop_go),
    .rd_data (rd_data)
  );

  assign dm_c = dm_q.c;
  assign dm_b = dm_q.b;
  assign dm_n = dm_q.n;
  assign dm_p = dm_q.p;
  assign idx  = idx_q;
  assign hop  = hop_q;

endmodule

// File: tb/tb_dm_hop_seq.sv
// tb/tb_dm_hop_seq.sv - directed self-checking bench for dm_hop_seq
module tb_dm_hop_seq;

  localparam logic [63:0] P_LOW  = {16'd49, 16'd29, 16'd21, 16'd20};
  localparam logic [63:0] P_HIGH = {16'd51, 16'd20, 16'd20, 16'd19};
  localparam logic [63:0] P_WT   = {16'd10, 16'd11, 16'd12, 16'd13};
  localparam logic [63:0] P_FIVE = {16'd5, 16'd5, 16'd5, 16'd5};

  logic clk_mod = 1'b0;
  logic rst;

  logic        en4, wr_en4, hop4;
  logic [1:0]  mode4, ext4, wr_addr4, idx4;
  logic [7:0]  dwell4;
  logic [15:0] wr_c4, wr_b4, wr_n4, wr_p4, dm_c4, dm_b4, dm_n4, dm_p4;

  logic        en2, wr_en2, hop2, ext2, wr_addr2, idx2;
  logic [1:0]  mode2;
  logic [7:0]  dwell2;
  logic [15:0] dm_c2, dm_b2, dm_n2, dm_p2;

  int n_checks = 0;
  int n_errs   = 0;

  always #5 clk_mod = ~clk_mod;

  dm_hop_seq #(.WIDTH(16), .DEPTH(4), .DWELL_W(8)) u_dut4 (
    .clk_mod (clk_mod), .rst (rst), .en (en4), .mode (mode4), .dwell (dwell4),
    .ext_sel (ext4), .wr_en (wr_en4), .wr_addr (wr_addr4),
    .wr_c (wr_c4), .wr_b (wr_b4), .wr_n (wr_n4), .wr_p (wr_p4),
    .dm_c (dm_c4), .dm_b (dm_b4), .dm_n (dm_n4), .dm_p (dm_p4),
    .idx (idx4), .hop (hop4)
  );

  dm_hop_seq #(.WIDTH(16), .DEPTH(2), .DWELL_W(8)) u_dut2 (
    .clk_mod (clk_mod), .rst (rst), .en (en2), .mode (mode2), .dwell (dwell2),
    .ext_sel (ext2), .wr_en (wr_en2), .wr_addr (wr_addr2),
    .wr_c (16'd0), .wr_b (16'd0), .wr_n (16'd0), .wr_p (16'd0),
    .dm_c (dm_c2), .dm_b (dm_b2), .dm_n (dm_n2), .dm_p (dm_p2),
    .idx (idx2), .hop (hop2)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_mod);
    #1;
  endtask

  task automatic set_wr4(input logic [63:0] d);
    {wr_c4, wr_b4, wr_n4, wr_p4} = d;
  endtask

  function automatic logic [63:0] dm4();
    return {dm_c4, dm_b4, dm_n4, dm_p4};
  endfunction

  initial begin
    logic [1:0] seq_exp [12];
    logic [1:0] pp_exp  [7];
    seq_exp = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd0};
    pp_exp  = '{2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0, 2'd1};

    rst = 1'b0;
    en4 = 1'b0; mode4 = 2'd0; dwell4 = 8'd0; ext4 = 2'd0; wr_en4 = 1'b0; wr_addr4 = 2'd0;
    set_wr4(64'd0);
    en2 = 1'b0; mode2 = 2'd0; dwell2 = 8'd0; ext2 = 1'b0; wr_en2 = 1'b0; wr_addr2 = 1'b0;

    #12;
    chk("rst_idx4", 64'(idx4), 64'd0);
    chk("rst_dm4", dm4(), P_LOW);
    chk("rst_hop4", 64'(hop4), 64'd0);
    chk("rst_dm2", {dm_c2, dm_b2, dm_n2, dm_p2}, P_LOW);
    rst = 1'b1;

    // legacy toggle on the two-entry instance
    mode2 = 2'd1; dwell2 = 8'd0; en2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk($sformatf("leg_idx_%0d", i), 64'(idx2), (i % 2 == 0) ? 64'd1 : 64'd0);
      chk($sformatf("leg_dm_%0d", i), {dm_c2, dm_b2, dm_n2, dm_p2},
          (i % 2 == 0) ? P_HIGH : P_LOW);
      chk($sformatf("leg_hop_%0d", i), 64'(hop2), 64'd1);
    end
    en2 = 1'b0;

    mode4 = 2'd1; dwell4 = 8'd2; en4 = 1'b1;
    for (int i = 0; i < 12; i++) begin
      tick();
      chk($sformatf("seq_idx_%0d", i), 64'(idx4), 64'(seq_exp[i]));
      chk($sformatf("seq_hop_%0d", i), 64'(hop4), (i % 3 == 2) ? 64'd1 : 64'd0);
      if (i == 2) chk("seq_dm_e1", dm4(), P_HIGH);
    end

    mode4 = 2'd2; dwell4 = 8'd0;
    for (int i = 0; i < 7; i++) begin
      tick();
      chk($sformatf("pp_idx_%0d", i), 64'(idx4), 64'(pp_exp[i]));
      chk($sformatf("pp_hop_%0d", i), 64'(hop4), 64'd1);
    end

    mode4 = 2'd3; dwell4 = 8'd1; ext4 = 2'd3;
    tick(); chk("ext_idx_a", 64'(idx4), 64'd1); chk("ext_hop_a", 64'(hop4), 64'd0);
    tick(); chk("ext_idx_b", 64'(idx4), 64'd3); chk("ext_hop_b", 64'(hop4), 64'd1);
    ext4 = 2'd1;
    tick(); chk("ext_idx_c", 64'(idx4), 64'd3); chk("ext_hop_c", 64'(hop4), 64'd0);
    tick(); chk("ext_idx_d", 64'(idx4), 64'd1); chk("ext_hop_d", 64'(hop4), 64'd1);
    tick(); chk("ext_hop_e", 64'(hop4), 64'd0);
    tick(); chk("ext_idx_f", 64'(idx4), 64'd1); chk("ext_hop_same", 64'(hop4), 64'd1);

    // write-through on the hop into entry 2, then delayed visibility in HOLD
    mode4 = 2'd1; dwell4 = 8'd0; wr_en4 = 1'b1; wr_addr4 = 2'd2; set_wr4(P_WT);
    tick();
    chk("wt_idx", 64'(idx4), 64'd2);
    chk("wt_dm", dm4(), P_WT);
    chk("wt_hop", 64'(hop4), 64'd1);
    wr_en4 = 1'b0; mode4 = 2'd0;
    tick();
    chk("hold_idx", 64'(idx4), 64'd2);
    chk("hold_dm", dm4(), P_WT);
    chk("hold_hop", 64'(hop4), 64'd0);
    wr_en4 = 1'b1; set_wr4(P_FIVE);
    tick();
    chk("hold_wr_early", dm4(), P_WT);
    wr_en4 = 1'b0;
    tick();
    chk("hold_wr_late", dm4(), P_FIVE);

    // asynchronous reset mid-dwell at idx 3
    mode4 = 2'd1; dwell4 = 8'd0;
    tick();
    chk("pre_rst_idx", 64'(idx4), 64'd3);
    chk("pre_rst_dm", dm4(), P_LOW);
    dwell4 = 8'd5;
    tick();
    chk("pre_rst_hop", 64'(hop4), 64'd0);
    #2 rst = 1'b0;
    #1;
    chk("arst_idx", 64'(idx4), 64'd0);
    chk("arst_dm", dm4(), P_LOW);
    chk("arst_hop", 64'(hop4), 64'd0);
    #1 rst = 1'b1;
    dwell4 = 8'd0;
    tick();
    chk("post_rst_idx1", 64'(idx4), 64'd1);
    chk("post_rst_dm1", dm4(), P_HIGH);
    tick();
    chk("post_rst_idx2", 64'(idx4), 64'd2);
    chk("post_rst_tbl2", dm4(), P_LOW);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
